// File: rtl/regfile_read_arbiter_if.sv
// Request/response and read-mux bus between requesters and the arbiter.
// Ports: req_valid/req_addr/req_ready, mux_select/mux_data, rsp_valid/rsp_data, busy.
interface regfile_read_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic [ADDR_W-1:0]         mux_select;
    logic [DATA_W-1:0]         mux_data;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;

    // Requesters plus the read mux: drive requests and mux data.
    modport master (
        output req_valid,
        output req_addr,
        output mux_data,
        input  req_ready,
        input  mux_select,
        input  rsp_valid,
        input  rsp_data,
        input  busy
    );

    // The arbiter itself.
    modport slave (
        input  req_valid,
        input  req_addr,
        input  mux_data,
        output req_ready,
        output mux_select,
        output rsp_valid,
        output rsp_data,
        output busy
    );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read mux among NUM_REQ
// requesters; registered select, registered one-hot response pulse.
// Ports: clk, rst (sync, active-high), bus (slave modport):
//   req_valid/req_addr in, req_ready out (one-hot grant),
//   mux_select out, mux_data in, rsp_valid/rsp_data out, busy out.
// Option: define REGFILE_ARB_ZERO_REG_EN to force reads of address 0 to 0.
module regfile_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_read_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        S_IDLE,
        S_READ
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   rr_ptr_d;
    logic [PTR_W-1:0]   gnt_id_q;
    logic [PTR_W-1:0]   gnt_id_d;
    logic [ADDR_W-1:0]  sel_q;
    logic [ADDR_W-1:0]  sel_d;
    logic [NUM_REQ-1:0] rsp_vld_q;
    logic [NUM_REQ-1:0] rsp_vld_d;
    logic [DATA_W-1:0]  rsp_data_q;
    logic [DATA_W-1:0]  rsp_data_d;
    logic [NUM_REQ-1:0] ready;

    logic               win_vld;
    logic [PTR_W-1:0]   win_idx;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  rd_data;

    // Scan from the requester after the last winner, wrapping once.
    always_comb begin
        int         idx;
        logic [PTR_W-1:0] idx_p;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        idx_p   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_p = PTR_W'(idx);
            if (!win_vld && bus.req_valid[idx_p]) begin
                win_vld = 1'b1;
                win_idx = idx_p;
            end
        end
    end

    assign win_addr = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];

    // The mux sees sel_q during READ, so address 0 is detected there.
`ifdef REGFILE_ARB_ZERO_REG_EN
    assign rd_data = (sel_q == '0) ? '0 : bus.mux_data;
`else
    assign rd_data = bus.mux_data;
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_id_d   = gnt_id_q;
        sel_d      = sel_q;
        rsp_vld_d  = '0;
        rsp_data_d = rsp_data_q;
        ready      = '0;
        case (state_q)
            S_IDLE: begin
                // Ready only goes to a valid requester, so any
                // winner is a handshake.
                if (win_vld) begin
                    ready    = NUM_REQ'(1) << win_idx;
                    sel_d    = win_addr;
                    gnt_id_d = win_idx;
                    rr_ptr_d = win_idx;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                rsp_data_d = rd_data;
                rsp_vld_d  = NUM_REQ'(1) << gnt_id_q;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= PTR_W'(NUM_REQ - 1);
            gnt_id_q   <= '0;
            sel_q      <= '0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_id_q   <= gnt_id_d;
            sel_q      <= sel_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.mux_select = sel_q;
    assign bus.rsp_valid  = rsp_vld_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.busy       = (state_q == S_READ);
endmodule
